// File: rtl/add_serial_pkg.sv
// add_serial_pkg
//   Shared definitions for the digit-serial adder/subtractor.
//   - state_t     : FSM state encoding (IDLE=0, ADD=1, DONE=2), 2 bits wide.
//   - count_width : width of the digit counter for a given digit count,
//                   clog2(n) with a floor of 1 bit.
package add_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int count_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// serial_digit_adder
//   Combinational DIGIT-bit adder slice used once per cycle by the serial
//   datapath.
//   Ports:
//     x, y   in  DIGIT  operand digits
//     cin    in  1      carry into bit 0 of the digit
//     s      out DIGIT  digit sum
//     cout   out 1      carry out of bit DIGIT-1
//     c_msb  out 1      carry into bit DIGIT-1 (for signed overflow)
module serial_digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] sum;

  assign sum  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  assign s    = sum[DIGIT-1:0];
  assign cout = sum[DIGIT];
  // Sum bit = x ^ y ^ carry_in, so the carry into the top bit falls out
  // of the top sum bit without a second adder.
  assign c_msb = x[DIGIT-1] ^ y[DIGIT-1] ^ sum[DIGIT-1];

endmodule

// File: rtl/add_sub_serial_n.sv
// add_sub_serial_n
//   Digit-serial adder/subtractor: consumes DIGIT bits per cycle of two
//   WIDTH-bit operands, LSB digit first. Subtract is a + ~b + 1.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      synchronous active-high reset
//     start      in   1      latch a/b/sub and begin an operation
//     sub        in   1      0: a+b, 1: a-b (sampled with start)
//     a, b       in   WIDTH  operands (sampled with start)
//     busy       out  1      operation in progress (state ADD)
//     done       out  1      result valid (state DONE)
//     out        out  WIDTH  result, mod 2^WIDTH
//     cout       out  1      carry out of MSB (subtract: 1 = no borrow)
//     ovf        out  1      signed overflow
//     dbg_state  out  2      current FSM state (add_serial_pkg::state_t)
//
//   Handshake: start is a one-cycle request, accepted at a rising edge only
//   when the block is IDLE or DONE; while busy=1 start is ignored. done
//   stays high, with out/cout/ovf held, until the next accepted start or
//   reset. There is no backpressure on the result side.
module add_sub_serial_n
  import add_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = count_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("add_sub_serial_n: WIDTH must be >= 2");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("add_sub_serial_n: DIGIT must evenly divide WIDTH");
  end

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              carry;
  logic [CW-1:0]     count;
  logic              last;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_cout;
  logic                   dig_cmsb;
  logic [WIDTH+DIGIT-1:0] out_cat;
  logic [WIDTH-1:0]       out_shift;

  serial_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (a_reg[DIGIT-1:0]),
    .y     (b_reg[DIGIT-1:0]),
    .cin   (carry),
    .s     (dig_s),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  assign last = (count == LAST);

  // New digit enters at the top; after N shifts the LSB digit lands at
  // bit 0. Going through a wider vector keeps DIGIT == WIDTH legal.
  assign out_cat   = {dig_s, out} >> DIGIT;
  assign out_shift = out_cat[WIDTH-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    if (start) state_nxt = ADD;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state == ADD);
    done      = (state == DONE);
    dbg_state = state;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      count <= '0;
      out   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg <= a;
            // Subtract as a + ~b + 1: invert b here, seed carry with 1.
            b_reg <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
            out   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
          end
        end
        ADD: begin
          out   <= out_shift;
          a_reg <= a_reg >> DIGIT;
          b_reg <= b_reg >> DIGIT;
          carry <= dig_cout;
          if (last) begin
            cout <= dig_cout;
            ovf  <= dig_cmsb ^ dig_cout;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_serial_n.sv
// tb_add_sub_serial_n
//   Four instances of add_sub_serial_n:
//     0: WIDTH=8  DIGIT=1    1: WIDTH=8  DIGIT=4
//     2: WIDTH=16 DIGIT=16   3: WIDTH=16 DIGIT=2
//   Expected {out, cout, ovf} are pushed when an operation is started and
//   popped when that instance raises done.
module tb_add_sub_serial_n;

  logic clk;
  logic rst;

  logic        start_i [4];
  logic        sub_i   [4];
  logic [15:0] a_i     [4];
  logic [15:0] b_i     [4];

  logic        busy_w  [4];
  logic        done_w  [4];
  logic        cout_w  [4];
  logic        ovf_w   [4];
  logic [1:0]  st_w    [4];
  logic [15:0] out_w   [4];

  logic [7:0]  out0, out1;
  logic [15:0] out2, out3;

  logic [17:0] exp_q[$];

  int n_cmp;
  int n_err;

  add_sub_serial_n #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .sub(sub_i[0]),
    .a(a_i[0][7:0]), .b(b_i[0][7:0]), .busy(busy_w[0]), .done(done_w[0]),
    .out(out0), .cout(cout_w[0]), .ovf(ovf_w[0]), .dbg_state(st_w[0])
  );
  add_sub_serial_n #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .sub(sub_i[1]),
    .a(a_i[1][7:0]), .b(b_i[1][7:0]), .busy(busy_w[1]), .done(done_w[1]),
    .out(out1), .cout(cout_w[1]), .ovf(ovf_w[1]), .dbg_state(st_w[1])
  );
  add_sub_serial_n #(.WIDTH(16), .DIGIT(16)) u2 (
    .clk(clk), .rst(rst), .start(start_i[2]), .sub(sub_i[2]),
    .a(a_i[2]), .b(b_i[2]), .busy(busy_w[2]), .done(done_w[2]),
    .out(out2), .cout(cout_w[2]), .ovf(ovf_w[2]), .dbg_state(st_w[2])
  );
  add_sub_serial_n #(.WIDTH(16), .DIGIT(2)) u3 (
    .clk(clk), .rst(rst), .start(start_i[3]), .sub(sub_i[3]),
    .a(a_i[3]), .b(b_i[3]), .busy(busy_w[3]), .done(done_w[3]),
    .out(out3), .cout(cout_w[3]), .ovf(ovf_w[3]), .dbg_state(st_w[3])
  );

  assign out_w[0] = {8'h00, out0};
  assign out_w[1] = {8'h00, out1};
  assign out_w[2] = out2;
  assign out_w[3] = out3;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int w_of(input int d);
    return (d < 2) ? 8 : 16;
  endfunction

  function automatic int n_of(input int d);
    case (d)
      0:       return 8;
      1:       return 2;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference: {result, carry out, signed overflow}
  function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic sub);
    logic [15:0] mask, aa, bb, r;
    logic [16:0] full;
    logic        c, v;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    aa   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    full = {1'b0, aa} + {1'b0, bb} + {16'h0000, sub};
    r    = full[15:0] & mask;
    c    = (w == 16) ? full[16] : full[8];
    v    = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    return {r, c, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: one operation on instance d; with noise, start is held high
  // with fresh random operands on every ADD cycle.
  task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input bit noise);
    int          lat;
    int          busy_n;
    bit          got;
    logic [17:0] e;
    @(negedge clk);
    a_i[d]     = a;
    b_i[d]     = b;
    sub_i[d]   = sub;
    start_i[d] = 1'b1;
    exp_q.push_back(model(w_of(d), a, b, sub));
    lat    = 0;
    busy_n = 0;
    got    = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (busy_w[d]) busy_n++;
      if (done_w[d]) begin
        got = 1;
      end else if (noise) begin
        a_i[d]     = 16'($urandom_range(0, 65535));
        b_i[d]     = 16'($urandom_range(0, 65535));
        sub_i[d]   = 1'($urandom_range(0, 1));
        start_i[d] = 1'b1;
      end else begin
        start_i[d] = 1'b0;
      end
    end
    start_i[d] = 1'b0;
    check("done_timeout", 32'(got), 32'd1);
    if (got) begin
      check("latency", 32'(lat), 32'(n_of(d) + 1));
      check("busy_cycles", 32'(busy_n), 32'(n_of(d)));
      if (exp_q.size() == 0) begin
        check("queue_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out", 32'(out_w[d]), 32'(e[17:2]));
        check("cout", 32'(cout_w[d]), 32'(e[1]));
        check("ovf", 32'(ovf_w[d]), 32'(e[0]));
      end
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int done_seen;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_i[i] = 1'b0;
      sub_i[i]   = 1'b0;
      a_i[i]     = 16'h0000;
      b_i[i]     = 16'h0000;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_state", 32'(st_w[i]), 32'd0);
      check("rst_busy", 32'(busy_w[i]), 32'd0);
      check("rst_done", 32'(done_w[i]), 32'd0);
      check("rst_out", 32'(out_w[i]), 32'd0);
      check("rst_cout_ovf", 32'({cout_w[i], ovf_w[i]}), 32'd0);
    end

    // Directed: 8-bit, 1 bit per cycle
    do_op(0, 16'h005A, 16'h003C, 1'b0, 1'b0);
    do_op(0, 16'h0010, 16'h0020, 1'b1, 1'b0);
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0);   // started from DONE
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold_done", 32'(done_w[0]), 32'd1);
    check("hold_out", 32'(out_w[0]), 32'h0000);
    check("hold_cout", 32'(cout_w[0]), 32'd1);

    // Directed: 8-bit, 4 bits per cycle
    do_op(1, 16'h007F, 16'h0001, 1'b0, 1'b0);
    do_op(1, 16'h0080, 16'h0001, 1'b1, 1'b0);

    // start hammered during ADD is ignored
    do_op(0, 16'h00C3, 16'h0071, 1'b1, 1'b1);
    do_op(1, 16'h0044, 16'h00BC, 1'b0, 1'b1);

    // Reset in the 4th ADD cycle abandons the operation
    @(negedge clk);
    a_i[0] = 16'h0033; b_i[0] = 16'h0044; sub_i[0] = 1'b0; start_i[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_state", 32'(st_w[0]), 32'd1);
    check("mid_busy", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", 32'(st_w[0]), 32'd0);
    check("abort_busy", 32'(busy_w[0]), 32'd0);
    check("abort_done", 32'(done_w[0]), 32'd0);
    check("abort_out", 32'(out_w[0]), 32'd0);
    check("abort_cout_ovf", 32'({cout_w[0], ovf_w[0]}), 32'd0);
    done_seen = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done_w[0]) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    do_op(0, 16'h0033, 16'h0044, 1'b1, 1'b0);

    // Random: 16-bit full width and 2 bits per cycle
    for (int d = 2; d < 4; d++) begin
      for (int i = 0; i < 1000; i++) begin
        do_op(d, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      end
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/add_sub_serial_n.md
# add_sub_serial_n

Parametrised digit-serial adder/subtractor: the next generation of the team's 1-bit serial adder. It processes DIGIT bits per cycle over a WIDTH-bit operand, supports add or subtract per operation, and reports carry-out and signed overflow. It sits between a register-file style operand source and a result consumer, trading latency for area in datapaths where a full-width adder is too large.

## Interface
- WIDTH, 8: operand/result width in bits; must be ≥ 2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH evenly. Elaboration fails otherwise.
- clk  in  1  sole clock, rising-edge.
- rst  in  1  synchronous active-high reset, sampled on rising clk.
- start  in  1  request: latch operands and begin an operation.
- sub  in  1  mode for the operation being started: 0 = a+b, 1 = a−b. Sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- busy  out  1  high while in ADD.
- done  out  1  high while in DONE; result outputs valid.
- out  out  WIDTH  result (two's-complement sum/difference, mod 2^WIDTH).
- cout  out  1  final carry out of MSB. For subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, ADD, DONE. Reset → IDLE.
- Reset (rst=1 at edge): state=IDLE; out, cout, ovf, internal a_reg, b_reg, carry, count all 0. Reset mid-operation abandons the operation; no done.
- IDLE or DONE with start=1: a_reg←a; b_reg←(sub ? ~b : b); carry←sub; count←0; out←0; cout←0; ovf←0; state←ADD. start in DONE begins a new operation directly (back-to-back).
- IDLE with start=0: hold. DONE with start=0: hold all outputs.
- ADD, each cycle: {c, s} = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry (DIGIT+1-bit result). out←{s, out[WIDTH-1:DIGIT]}; a_reg, b_reg shift right by DIGIT; carry←c; count←count+1.
- ADD, last digit (count == WIDTH/DIGIT−1): additionally cout←c; ovf←(carry into bit DIGIT-1 of this digit) XOR c; state←DONE.
- start while in ADD: ignored; operands, mode, and progress unaffected.
- count width: clog2(WIDTH/DIGIT), minimum 1 bit. No wrap is ever reached: state leaves ADD at the terminal count.
- DIGIT == WIDTH: ADD lasts one cycle; block behaves as a registered full-width adder.

## Timing
- start accepted at edge k → ADD for edges k+1 … k+N, N = WIDTH/DIGIT.
- busy high in cycles after edge k through edge k+N; done high from edge k+N until the next accepted start or reset.
- Latency start→done: N+1 clock edges including the accepting edge. Throughput with back-to-back start in DONE: one result per N+1 cycles.
- out holds partial results during ADD; valid only when done=1.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package add_serial_pkg: state enum (IDLE=0, ADD=1, DONE=2, 2-bit); function for count width.
- Sub-module serial_digit_adder: combinational DIGIT-bit adder with inputs x, y, cin; outputs s, cout, and carry into MSB (c_msb) for overflow. Top holds FSM, shift registers, and counters.

## Test plan
- WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, sub=0 → after 9 edges done=1, out=0x96, cout=0, ovf=1; busy high for exactly 8 cycles.
- WIDTH=8, DIGIT=1: a=0x10, b=0x20, sub=1 → out=0xF0, cout=0, ovf=0; then a=0xFF, b=0x01, sub=0 started in DONE → out=0x00, cout=1, ovf=0.
- WIDTH=8, DIGIT=4: a=0x7F, b=0x01, sub=0 → done after 3 edges, out=0x80, cout=0, ovf=1; a=0x80, b=0x01, sub=1 → out=0x7F, cout=1, ovf=1.
- start pulsed with different a/b on every cycle of ADD → result matches the first accepted operands only; done timing unchanged.
- rst asserted on the 4th ADD cycle → next cycle state=IDLE, busy=0, done=0, out=0, cout=0, ovf=0; subsequent start completes normally.
- WIDTH=16, DIGIT=16 and DIGIT=2: random 1000 operations each, compare out/cout/ovf against reference (a±b) and latency N+1.
